dmem_pipelined: RTL

Parametrised successor to the single-cycle data memory, for the multi-cycle and pipelined datapaths. It has a valid/ready request port and a configurable fixed read latency. Writes use byte-lane strobes. Misaligned and out-of-range accesses raise an error flag. After reset, a hardware init sequence zero-fills the array; no file preload is used.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_pipelined_lat_pipe.sv | 48 ++++
 rtl/dmem_pipelined.sv | 99 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the pipelined data memory: lane/offset derivation and FSM encoding.
package dmem_pkg;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_pipelined_lat_pipe.sv
// Fixed-depth response pipeline carrying {valid, write, err, rdata}; fully cleared on reset.
module lat_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic              write_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              vld_o,
  output logic              write_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] write_q;
  logic [STAGES-1:0] err_q;
  logic [DATA_W-1:0] rdata_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      write_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < STAGES; i++) rdata_q[i] <= '0;
    end else begin
      vld_q[0]   <= vld_i;
      write_q[0] <= write_i;
      err_q[0]   <= err_i;
      rdata_q[0] <= rdata_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]   <= vld_q[i-1];
        write_q[i] <= write_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign vld_o   = vld_q[STAGES-1];
  assign write_o = write_q[STAGES-1];
  assign err_o   = err_q[STAGES-1];
  assign rdata_o = rdata_q[STAGES-1];

endmodule

// File: rtl/dmem_pipelined.sv
// Data memory with valid/ready request port, byte strobes, fixed read latency and
// a hardware zero-fill sequence after reset.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8192,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int LANES = lane_count(DATA_W);
  localparam int LSB   = lsb_of(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              acc_err;
  logic              store_we;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);

  // Gate with rst so a request presented on a reset edge never touches the array.
  assign accept    = req_valid && req_ready && !rst;
  assign word_addr = req_addr >> LSB;
  assign idx       = word_addr[IDX_W-1:0];
  assign acc_err   = ((req_addr & ADDR_W'(LANES - 1)) != '0) ||
                     (word_addr >= ADDR_W'(DEPTH));
  assign store_we  = accept && req_write && !acc_err;
  assign rd_word   = mem_q[idx];

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT && !rst) begin
      mem_q[cnt_q] <= '0;
    end else if (store_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (req_wstrb[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Non-accepted cycles inject all-zero entries so idle response fields read 0.
  lat_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (accept),
    .write_i (accept && req_write),
    .err_i   (accept && acc_err),
    .rdata_i ((accept && !req_write && !acc_err) ? rd_word : '0),
    .vld_o   (resp_valid),
    .write_o (resp_write),
    .err_o   (resp_err),
    .rdata_o (resp_rdata)
  );

endmodule
